alu_seq_core: RTL and testbench
===============================

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width; legal values are powers of two, 8 to 64.
REQ-002 Derived constant SHW = log2(WIDTH) SHALL set the shift-amount width.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  WIDTH  shared data bus for operand and opcode loads.
REQ-006 ld_a  input  1  load strobe: A <= in.
REQ-007 ld_b  input  1  load strobe: B <= in.
REQ-008 ld_op  input  1  load strobe: OP <= in[3:0].
REQ-009 start  input  1  one-cycle request to execute OP on A, B.
REQ-010 F  output  WIDTH  registered result.
REQ-011 FR  output  4  registered flags {ZF, CF, OF, SF}.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse on the edge that writes F/FR.

Function
REQ-014 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB (A-B), 6 SLT (signed, F=1/0), 7 SLL, 8 SRL, 9 SRA, 10 MUL (macro-dependent), 11-15 illegal.
REQ-015 FSM states SHALL be IDLE, EXEC, SHIFT, MUL; IDLE->EXEC on start for opcodes 0-6 and illegal; IDLE->SHIFT for 7-9; IDLE->MUL for 10 when enabled; EXEC/SHIFT/MUL->IDLE on completion.
REQ-016 Load strobes SHALL take effect only in IDLE; strobes while busy are ignored; several strobes in one cycle all load from in.
REQ-017 A load and start in the same IDLE cycle SHALL execute on the pre-load register values; the load still completes.
REQ-018 start while busy SHALL be ignored; no queueing.
REQ-019 busy SHALL rise on the edge accepting start and fall on the edge that pulses done.
REQ-020 Latency from the start edge to done SHALL be 1 cycle for EXEC ops, B[SHW-1:0]+1 cycles for shifts (iterative, one bit per cycle), WIDTH+1 cycles for MUL (shift-add).
REQ-021 Shift amount SHALL be B[SHW-1:0]; upper B bits ignored; amount 0 returns A.
REQ-022 ADD/SUB SHALL use WIDTH+1-bit arithmetic: CF = carry-out (ADD) or borrow (SUB); OF = signed overflow; both 0 for all other ops.
REQ-023 ZF = (F==0), SF = F[WIDTH-1] for every op.
REQ-024 MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-025 Illegal opcodes SHALL complete in 1 cycle with F=0, FR={1,0,0,0}.
REQ-026 F and FR SHALL hold their values between operations.

Reset
REQ-027 rst_n low SHALL immediately force A, B, OP, F to 0, FR to 0, busy and done to 0, FSM to IDLE, and clear iteration counters.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after release is accepted normally.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN defined: opcode 10 SHALL run the MUL state per REQ-020/024.
REQ-030 ALU_SEQ_MUL_EN undefined: MUL state and multiplier logic SHALL be absent and opcode 10 SHALL be treated as illegal per REQ-025.

Verification
REQ-031 A=1, B=2, OP=0, start -> done after 1 cycle, F=0, FR=1000.
REQ-032 A=FFFF_FFFF, B=1, OP=4 -> F=0, FR=1100; then OP=5 -> F=FFFF_FFFE, FR=0001.
REQ-033 A=7FFF_FFFF, B=1, OP=4 -> F=8000_0000, FR=0011; A=FFFF_FFFF, B=1, OP=6 -> F=1.
REQ-034 A=1, B=5, OP=7 -> busy 6 cycles, done at cycle 6, F=0000_0020; OP=9 with A=8000_0000, B=31 -> F=FFFF_FFFF, FR=0001.
REQ-035 A=3, B=9, OP=10 -> with macro: done at cycle 33, F=27; without macro: done at cycle 1, F=0, FR=1000.
REQ-036 rst_n pulsed low during SHIFT with B=20 -> no done, F=0, busy=0; ld_a during busy ignored; start on same edge as ld_a uses old A.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: shared load bus, strobes and result/status signals of alu_seq_core.
// master: the requester driving operands and strobes; slave: the ALU core.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in;
  logic             ld_a;
  logic             ld_b;
  logic             ld_op;
  logic             start;
  logic [WIDTH-1:0] F;
  logic [3:0]       FR;
  logic             busy;
  logic             done;

  modport master (
    output in, ld_a, ld_b, ld_op, start,
    input  F, FR, busy, done
  );

  modport slave (
    input  in, ld_a, ld_b, ld_op, start,
    output F, FR, busy, done
  );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with single-cycle logic/arith ops, iterative
// one-bit-per-cycle shifts and an optional shift-add multiplier.
// Optional feature macro: ALU_SEQ_MUL_EN (defined -> opcode 10 multiplies,
// undefined -> opcode 10 is illegal and the multiplier is not built).
// Operands and opcode are snapshotted on the start edge, so a load in the
// same cycle as start lands in A/B/OP but does not affect that operation.
module alu_seq_core #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0]    OP_MUL  = 4'd10;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, b_r, opa_r, opb_r, f_r;
  logic [3:0]       op_r, opc_r, fr_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r, done_r;
  logic             fin_s, cf_s, of_s;
  logic [WIDTH-1:0] res_s, shift_nx_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [3:0]       flags_s;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_r, acc_nx_s;
`endif

  assign bus.F    = f_r;
  assign bus.FR   = fr_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state: dispatch on the opcode held in OP when start is seen
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          case (op_r)
            OP_SLL, OP_SRL, OP_SRA: state_nx_s = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:                 state_nx_s = S_MUL;
`endif
            default:                state_nx_s = S_EXEC;
          endcase
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_EXEC:  state_nx_s = S_IDLE;
      S_SHIFT: begin
        if (cnt_r == CNT_ZERO) state_nx_s = S_IDLE;
        else                   state_nx_s = S_SHIFT;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (cnt_r == CNT_ZERO) state_nx_s = S_IDLE;
        else                   state_nx_s = S_MUL;
      end
`endif
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM outputs: completion flag, result/flags to write, next iteration values
  always_comb begin
    fin_s      = 1'b0;
    res_s      = {WIDTH{1'b0}};
    cf_s       = 1'b0;
    of_s       = 1'b0;
    shift_nx_s = opa_r;
    sum_s      = {1'b0, opa_r} + {1'b0, opb_r};
    diff_s     = {1'b0, opa_r} - {1'b0, opb_r};
`ifdef ALU_SEQ_MUL_EN
    acc_nx_s   = acc_r + (opb_r[0] ? opa_r : {WIDTH{1'b0}});
`endif
    case (state_r)
      S_EXEC: begin
        fin_s = 1'b1;
        case (opc_r)
          OP_AND: res_s = opa_r & opb_r;
          OP_OR:  res_s = opa_r | opb_r;
          OP_XOR: res_s = opa_r ^ opb_r;
          OP_NOR: res_s = ~(opa_r | opb_r);
          OP_ADD: begin
            res_s = sum_s[WIDTH-1:0];
            cf_s  = sum_s[WIDTH];
            of_s  = (opa_r[WIDTH-1] == opb_r[WIDTH-1]) && (sum_s[WIDTH-1] != opa_r[WIDTH-1]);
          end
          OP_SUB: begin
            res_s = diff_s[WIDTH-1:0];
            cf_s  = diff_s[WIDTH];
            of_s  = (opa_r[WIDTH-1] != opb_r[WIDTH-1]) && (diff_s[WIDTH-1] != opa_r[WIDTH-1]);
          end
          OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(opa_r) < $signed(opb_r))};
          default: res_s = {WIDTH{1'b0}};
        endcase
      end
      S_SHIFT: begin
        case (opc_r)
          OP_SLL:  shift_nx_s = {opa_r[WIDTH-2:0], 1'b0};
          OP_SRL:  shift_nx_s = {1'b0, opa_r[WIDTH-1:1]};
          default: shift_nx_s = {opa_r[WIDTH-1], opa_r[WIDTH-1:1]};
        endcase
        if (cnt_r == CNT_ZERO) begin
          fin_s = 1'b1;
          res_s = opa_r;
        end else begin
          fin_s = 1'b0;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (cnt_r == CNT_ZERO) begin
          fin_s = 1'b1;
          res_s = acc_r;
        end else begin
          fin_s = 1'b0;
        end
      end
`endif
      default: fin_s = 1'b0;
    endcase
    flags_s = {(res_s == {WIDTH{1'b0}}), cf_s, of_s, res_s[WIDTH-1]};
  end

  // Datapath: loads, operand snapshot, iteration, result/flag writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= 4'd0;
      opa_r  <= {WIDTH{1'b0}};
      opb_r  <= {WIDTH{1'b0}};
      opc_r  <= 4'd0;
      cnt_r  <= CNT_ZERO;
      f_r    <= {WIDTH{1'b0}};
      fr_r   <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_r  <= {WIDTH{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.ld_a)  a_r  <= bus.in;
          if (bus.ld_b)  b_r  <= bus.in;
          if (bus.ld_op) op_r <= bus.in[3:0];
          if (bus.start) begin
            opa_r  <= a_r;
            opb_r  <= b_r;
            opc_r  <= op_r;
            busy_r <= 1'b1;
            cnt_r  <= CNT_ZERO;
            if (state_nx_s == S_SHIFT) cnt_r <= {1'b0, b_r[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
            if (state_nx_s == S_MUL) begin
              cnt_r <= CNT_MUL;
              acc_r <= {WIDTH{1'b0}};
            end
`endif
          end
        end
        S_SHIFT: begin
          if (!fin_s) begin
            opa_r <= shift_nx_s;
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          if (!fin_s) begin
            acc_r <= acc_nx_s;
            opa_r <= {opa_r[WIDTH-2:0], 1'b0};
            opb_r <= {1'b0, opb_r[WIDTH-1:1]};
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`endif
        default: ;
      endcase
      if (fin_s) begin
        f_r    <= res_s;
        fr_r   <= flags_s;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed self-checking bench for alu_seq_core (WIDTH=32).
// Expectations for opcode 10 follow ALU_SEQ_MUL_EN as seen by this bench.
module tb_alu_seq_core;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   busy_gap;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.in = a; bus.ld_a = 1'b1;
    step();
    bus.ld_a = 1'b0; bus.in = b; bus.ld_b = 1'b1;
    step();
    bus.ld_b = 1'b0; bus.in = {28'd0, op}; bus.ld_op = 1'b1;
    step();
    bus.ld_op = 1'b0; bus.in = 32'd0;
  endtask

  task automatic kick(input string name);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({name, "_busy_rise"}, {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_done(input string name, input int lat, input logic [31:0] f,
                           input logic [3:0] fr);
    int cnt;
    cnt = 0;
    busy_gap = 0;
    while (bus.done !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_gap++;
    end
    chk({name, "_latency"}, 64'(cnt), 64'(lat));
    chk({name, "_busy_gap"}, 64'(busy_gap), 64'd0);
    chk({name, "_F"}, {32'd0, bus.F}, {32'd0, f});
    chk({name, "_FR"}, {60'd0, bus.FR}, {60'd0, fr});
    chk({name, "_busy_fall"}, {63'd0, bus.busy}, 64'd0);
    step();
    chk({name, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    chk({name, "_F_hold"}, {32'd0, bus.F}, {32'd0, f});
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input int lat, input logic [31:0] f,
                     input logic [3:0] fr);
    load(a, b, op);
    kick(name);
    wait_done(name, lat, f, fr);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in = 32'd0; bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.ld_op = 1'b0; bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_F", {32'd0, bus.F}, 64'd0);
    chk("rst_FR", {60'd0, bus.FR}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    step();

    run("and",      32'h0000_0001, 32'h0000_0002, 4'd0, 1, 32'h0000_0000, 4'b1000);
    run("or",       32'h0000_0001, 32'h0000_0002, 4'd1, 1, 32'h0000_0003, 4'b0000);
    run("xor",      32'h0000_0006, 32'h0000_0003, 4'd2, 1, 32'h0000_0005, 4'b0000);
    run("nor",      32'h0000_0000, 32'h0000_0000, 4'd3, 1, 32'hFFFF_FFFF, 4'b0001);
    run("add_cy",   32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 1, 32'h0000_0000, 4'b1100);
    run("sub",      32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 1, 32'hFFFF_FFFE, 4'b0001);
    run("add_ov",   32'h7FFF_FFFF, 32'h0000_0001, 4'd4, 1, 32'h8000_0000, 4'b0011);
    run("sub_brw",  32'h0000_0001, 32'h0000_0002, 4'd5, 1, 32'hFFFF_FFFF, 4'b0101);
    run("slt",      32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 1, 32'h0000_0001, 4'b0000);
    run("slt_no",   32'h0000_0001, 32'hFFFF_FFFF, 4'd6, 1, 32'h0000_0000, 4'b1000);
    run("sll",      32'h0000_0001, 32'h0000_0005, 4'd7, 6, 32'h0000_0020, 4'b0000);
    run("srl",      32'h8000_0000, 32'h0000_0004, 4'd8, 5, 32'h0800_0000, 4'b0000);
    run("sra",      32'h8000_0000, 32'h0000_001F, 4'd9, 32, 32'hFFFF_FFFF, 4'b0001);
    run("sll_amt0", 32'h0000_1234, 32'h0000_0020, 4'd7, 1, 32'h0000_1234, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
    run("mul",      32'h0000_0003, 32'h0000_0009, 4'd10, 33, 32'h0000_001B, 4'b0000);
`else
    run("mul_ill",  32'h0000_0003, 32'h0000_0009, 4'd10, 1, 32'h0000_0000, 4'b1000);
`endif
    run("illegal",  32'h0000_0003, 32'h0000_0009, 4'd15, 1, 32'h0000_0000, 4'b1000);

    // Load of A on the start edge: operation uses old A, new A is kept.
    load(32'h0000_0005, 32'h0000_0003, 4'd4);
    bus.in = 32'h0000_0100; bus.ld_a = 1'b1;
    kick("ld_start");
    bus.ld_a = 1'b0; bus.in = 32'd0;
    wait_done("ld_start", 1, 32'h0000_0008, 4'b0000);
    kick("ld_after");
    wait_done("ld_after", 1, 32'h0000_0103, 4'b0000);

    // Strobes and start while busy are ignored.
    load(32'h0000_0001, 32'h0000_000A, 4'd7);
    kick("busy_ign");
    bus.in = 32'h0000_FFFF; bus.ld_a = 1'b1; bus.ld_b = 1'b1; bus.start = 1'b1;
    step();
    bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.start = 1'b0; bus.in = 32'd0;
    wait_done("busy_ign", 10, 32'h0000_0400, 4'b0000);
    kick("busy_rerun");
    wait_done("busy_rerun", 11, 32'h0000_0400, 4'b0000);

    // Reset in the middle of a long shift aborts it silently.
    load(32'h0000_0001, 32'h0000_0014, 4'd7);
    kick("mid_rst");
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_F", {32'd0, bus.F}, 64'd0);
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
    step();
    rst_n = 1'b1;
    busy_gap = 0;
    repeat (25) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) busy_gap++;
    end
    chk("mid_rst_quiet", 64'(busy_gap), 64'd0);
    chk("mid_rst_Fq", {32'd0, bus.F}, 64'd0);
    kick("post_rst");
    wait_done("post_rst", 1, 32'h0000_0000, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
